mem_copy_engine: RTL
====================

# mem_copy_engine

Bus-initiator block that drives the read and write ports of the single-cycle registered main memory to copy a block of words from a source region to a destination region. It sits between a control source (CPU/test sequencer) and the memory. It sustains one word per cycle by overlapping reads and writes, and handles overlapping regions with memmove semantics.

## Interface
- ADDR_WIDTH, 16, memory address width; matches the memory instance.
- DATA_WIDTH, 16, memory word width; matches the memory instance.
- LEN_WIDTH, 16, width of the word-count field.

- clock  input  1  rising-edge clock shared with the memory.
- reset_n  input  1  reset; one clock; asynchronous, active-low.
- start  input  1  copy request; sampled only in IDLE.
- src_addr  input  ADDR_WIDTH  first source word; latched on accepted start.
- dst_addr  input  ADDR_WIDTH  first destination word; latched on accepted start.
- length  input  LEN_WIDTH  number of words to copy; latched on accepted start.
- busy  output  1  copy in progress.
- done  output  1  one-cycle pulse when the copy completes.
- mem_read_addr  output  ADDR_WIDTH  to memory read_addr; registered.
- mem_read_out  input  DATA_WIDTH  from memory read_out.
- mem_write_addr  output  ADDR_WIDTH  to memory write_addr; registered.
- mem_write_data  output  DATA_WIDTH  to memory write_data; combinational copy of mem_read_out.
- mem_write_ctrl  output  1  to memory write_ctrl; registered.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1:
  - If length=0 or dst_addr=src_addr: go to DONE. No memory writes.
  - Otherwise: latch the configuration, compute the direction, and go to RUN.
- Direction:
  - d = (dst_addr - src_addr) mod 2^ADDR_WIDTH.
  - If 0 < d < length: BACKWARD. The first read is src+length-1, the first write is dst+length-1, and addresses decrement.
  - Otherwise: FORWARD. Start at src/dst and increment.
  - All address arithmetic wraps modulo 2^ADDR_WIDTH.
- RUN:
  - Each cycle, issue the next read address and decrement the remaining count.
  - After issuing the last read, go to DRAIN.
- Write pipeline: mem_write_ctrl/mem_write_addr are the read-issue valid and address of the previous cycle, delayed one register stage, mapped to the matching destination address.
- DRAIN: the final write is pending; go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- start outside IDLE is ignored. Inputs are don't-care after acceptance.
- The memory is write-first on the same edge. The chosen direction guarantees that no address is written before its last pending read.

## Timing
- Reset values: busy=0, done=0, mem_write_ctrl=0, mem_read_addr=0, mem_write_addr=0. State=IDLE.
- An accepted start at edge E0 with length N≥1 gives:
  - Read i is issued in the cycle after E(i).
  - The memory captures read i at E(i+1).
  - Write i commits at E(i+2).
  - The final write commits at E(N+1).
- busy is high from the cycle after E0 through the cycle ending at E(N+1), i.e. N+1 cycles.
- done pulses in the cycle after E(N+1); busy is low in that cycle.
- Sustained throughput is 1 word/cycle; total start-to-done is N+2 cycles.
- length=0 or dst=src: done pulses in the cycle after E0, busy stays low, and mem_write_ctrl is never asserted.
- Back-to-back: a start in the done cycle is ignored. The next start is accepted the cycle after.
- reset_n low mid-copy:
  - All outputs return to reset values immediately (asynchronously) and state goes to IDLE.
  - mem_write_ctrl drops before the next edge, so no further write commits.
  - No done pulse is produced.

## Structure
- Package mem_copy_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the direction enum (FORWARD, BACKWARD);
  - localparam MEM_READ_LATENCY = 1, which sets the write-pipeline depth.
- Sub-module copy_addr_gen: loadable wrapping address counter with an up/down select. It is instantiated twice, for source and destination.
- The top level holds the FSM, the remaining-count counter, overlap detection and the write-delay register.

## Test plan
All scenarios use the engine connected to a real memory instance with ADDR_WIDTH=16 and DATA_WIDTH=16.
- Basic copy: preload mem[0x10..0x13]=A0,A1,A2,A3; src=0x10, dst=0x40, len=4.
  - mem[0x40..0x43]=A0..A3.
  - busy is high 5 cycles; done occurs 6 cycles after the start edge.
  - Exactly 4 write_ctrl cycles.
- Overlap, dst>src: preload mem[0x20..0x25]=1..6; src=0x20, dst=0x22, len=4.
  - mem[0x22..0x25]=1,2,3,4; mem[0x20..0x21]=1,2.
  - Writes descend from 0x25.
- Overlap, dst<src: preload mem[0x20..0x25]=1..6; src=0x22, dst=0x20, len=4.
  - mem[0x20..0x23]=3,4,5,6; mem[0x24..0x25]=5,6.
- Wrap: preload mem[0xFFFE]=B0, mem[0xFFFF]=B1, mem[0]=B2, mem[1]=B3; src=0xFFFE, dst=0x0100, len=4.
  - mem[0x100..0x103]=B0..B3.
- Degenerate requests: len=0, then src=dst=0x30 with len=5.
  - Each gives a done pulse 1 cycle after start, busy stays 0, and there are no writes.
- Robustness during an active copy: start len=8 from src=0x10 to dst=0x80.
  - Pulse start at cycle 3: ignored.
  - Drop reset_n after the 2nd write commit: write_ctrl low immediately, only mem[0x80..0x81] changed, no done pulse.
  - After reset release, a new copy completes correctly.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the memory copy engine.
package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    FORWARD  = 1'b0,
    BACKWARD = 1'b1
  } dir_t;

  // Cycles from read address to read data; sets the write-pipeline depth.
  localparam int MEM_READ_LATENCY = 1;

endpackage

// File: rtl/copy_addr_gen.sv
// Loadable wrapping address counter; load wins over step, step moves one word
// in the selected direction with modulo-2^WIDTH wrap.
module copy_addr_gen
  import mem_copy_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  input  logic             step,
  input  dir_t             dir,
  output logic [WIDTH-1:0] addr
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_addr;
    end else if (step) begin
      addr_d = (dir == BACKWARD) ? addr_q - ONE : addr_q + ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy engine with memmove semantics: one read issued per cycle, each
// write follows its read by the memory read latency.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_out,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_ctrl
);

  localparam int CMP_W = (ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                 state_q, state_d;
  dir_t                   dir_q, dir_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0]  diff, len_m1, src_first, dst_first;
  logic [ADDR_WIDTH-1:0]  src_cur, dst_cur;
  logic [CMP_W-1:0]       diff_x, len_x;
  logic                   backward, load, step;

  logic [MEM_READ_LATENCY-1:0] wr_vld_q, wr_vld_d;
  logic [ADDR_WIDTH-1:0]       wr_addr_q [MEM_READ_LATENCY];
  logic [ADDR_WIDTH-1:0]       wr_addr_d [MEM_READ_LATENCY];

  // Overlap with the destination ahead of the source must copy from the top down.
  assign diff      = dst_addr - src_addr;
  assign diff_x    = CMP_W'(diff);
  assign len_x     = CMP_W'(length);
  assign backward  = (diff != '0) && (diff_x < len_x);
  assign len_m1    = ADDR_WIDTH'(length) - ADDR_ONE;
  assign src_first = backward ? src_addr + len_m1 : src_addr;
  assign dst_first = backward ? dst_addr + len_m1 : dst_addr;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((length == '0) || (dst_addr == src_addr)) begin
            state_d = DONE;
          end else begin
            load    = 1'b1;
            dir_d   = backward ? BACKWARD : FORWARD;
            cnt_d   = length - LEN_ONE;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == '0) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q - LEN_ONE;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dir_q   <= FORWARD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  copy_addr_gen #(.WIDTH(ADDR_WIDTH)) u_src_gen (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .load_addr (src_first),
    .step      (step),
    .dir       (dir_q),
    .addr      (src_cur)
  );

  copy_addr_gen #(.WIDTH(ADDR_WIDTH)) u_dst_gen (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .load_addr (dst_first),
    .step      (step),
    .dir       (dir_q),
    .addr      (dst_cur)
  );

  // The destination counter tracks the read in flight; delay it to meet the data.
  always_comb begin
    wr_vld_d[0]  = (state_q == RUN);
    wr_addr_d[0] = dst_cur;
    for (int i = 1; i < MEM_READ_LATENCY; i++) begin
      wr_vld_d[i]  = wr_vld_q[i-1];
      wr_addr_d[i] = wr_addr_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_vld_q <= '0;
      for (int i = 0; i < MEM_READ_LATENCY; i++) begin
        wr_addr_q[i] <= '0;
      end
    end else begin
      wr_vld_q <= wr_vld_d;
      for (int i = 0; i < MEM_READ_LATENCY; i++) begin
        wr_addr_q[i] <= wr_addr_d[i];
      end
    end
  end

  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign mem_read_addr  = src_cur;
  assign mem_write_ctrl = wr_vld_q[MEM_READ_LATENCY-1];
  assign mem_write_addr = wr_addr_q[MEM_READ_LATENCY-1];
  assign mem_write_data = mem_read_out;

endmodule
